// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: sequences the pipeline stage clock for the stepped MIPS CPU.
// A step press or the free-run timer issues one stretched pipe_clk tick
// (HIGH_CYC cycles high, HIGH_CYC low). Each tick is followed by an LCD
// refresh handshake, and the PC sampled during the tick is checked against a
// breakpoint.
//
// Optional feature: define STEP_CTRL_ACK_TIMEOUT_EN to bound the wait for
// lcd_ack to ACK_TIMEOUT cycles. On a timeout the sticky ack_timeout flag is
// set and the refresh is treated as acknowledged.
//
// Ports:
//   CCLK, rstn   system clock, asynchronous active-low reset
//   step         debounced step button (level); its rising edge issues a tick
//   run_sw       1 = free-run, 0 = single-step
//   clr          synchronous clear of tick_cnt
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc           IF-stage PC
//   lcd_ack      display accepted the refresh
//   pipe_clk     clock to the pipeline stages
//   tick_cnt     ticks issued, modulo 256
//   lcd_req      refresh request
//   halted       breakpoint hit
//   state        FSM state (debug)
//   ack_timeout  sticky lcd_ack timeout flag
module pipe_step_ctrl #(
   parameter int unsigned HIGH_CYC    = 4,
   parameter int unsigned RUN_DIV     = 1000000,
   parameter int unsigned ACK_TIMEOUT = 65535
) (
   input  logic        CCLK,
   input  logic        rstn,
   input  logic        step,
   input  logic        run_sw,
   input  logic        clr,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] pc,
   input  logic        lcd_ack,
   output logic        pipe_clk,
   output logic [7:0]  tick_cnt,
   output logic        lcd_req,
   output logic        halted,
   output logic [2:0]  state,
   output logic        ack_timeout
);

   // One shared phase counter, sized for the longest interval it must measure
   localparam int unsigned MAX_HR  = (HIGH_CYC > RUN_DIV) ? HIGH_CYC : RUN_DIV;
   localparam int unsigned CNT_MAX = (MAX_HR > ACK_TIMEOUT) ? MAX_HR : ACK_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TICK_HI  = 3'd1,
      TICK_LO  = 3'd2,
      REFRESH  = 3'd3,
      RUN_WAIT = 3'd4,
      HALT     = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pc_q;
   logic               step_q, run_q;
   logic               step_rise, run_fall, bp_hit, ack_done, pc_load;

   assign step_rise = step & ~step_q;
   assign run_fall  = run_q & ~run_sw;
   assign bp_hit    = bp_en & (pc_q == bp_addr);
   assign state     = 3'(state_q);

`ifdef STEP_CTRL_ACK_TIMEOUT_EN
   logic to_hit;
   // Missing ack after ACK_TIMEOUT refresh cycles counts as an ack
   assign to_hit   = (state_q == REFRESH) && !lcd_ack &&
                     (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
   assign ack_done = lcd_ack | to_hit;

   always_ff @(posedge CCLK or negedge rstn) begin
      if (!rstn) ack_timeout <= 1'b0;
      else if (to_hit) ack_timeout <= 1'b1;
   end
`else
   assign ack_done    = lcd_ack;
   assign ack_timeout = 1'b0;
`endif

   // Next-state and phase counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (step_rise) begin
               state_d = TICK_HI;
               cnt_d   = '0;
            end else if (run_sw) begin
               state_d = RUN_WAIT;
               cnt_d   = '0;
            end
         end
         TICK_HI: begin
            if (cnt_q == CNT_W'(HIGH_CYC - 1)) begin
               state_d = TICK_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TICK_LO: begin
            if (cnt_q == CNT_W'(HIGH_CYC - 1)) begin
               state_d = REFRESH;
               cnt_d   = '0;
               pc_load = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REFRESH: begin
            if (ack_done) begin
               cnt_d = '0;
               if (bp_hit)      state_d = HALT;
               else if (run_sw) state_d = RUN_WAIT;
               else             state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN_WAIT: begin
            if (!run_sw) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(RUN_DIV - 1)) begin
               state_d = TICK_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HALT: begin
            // A step press single-steps past the breakpoint
            if (step_rise) begin
               state_d = TICK_HI;
               cnt_d   = '0;
            end else if (run_fall) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counters and registered outputs (decoded from next state)
   always_ff @(posedge CCLK or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         step_q   <= 1'b0;
         run_q    <= 1'b0;
         pc_q     <= '0;
         pipe_clk <= 1'b0;
         lcd_req  <= 1'b0;
         halted   <= 1'b0;
         tick_cnt <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step;
         run_q    <= run_sw;
         pipe_clk <= (state_d == TICK_HI);
         lcd_req  <= (state_d == REFRESH);
         halted   <= (state_d == HALT);
         if (pc_load) pc_q <= pc;
         // clr wins over the tick increment
         if (clr)
            tick_cnt <= '0;
         else if ((state_d == TICK_HI) && (state_q != TICK_HI))
            tick_cnt <= tick_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl with HIGH_CYC=4, RUN_DIV=10, ACK_TIMEOUT=8.
module tb_pipe_step_ctrl;

   localparam int unsigned HIGH_CYC    = 4;
   localparam int unsigned RUN_DIV     = 10;
   localparam int unsigned ACK_TIMEOUT = 8;

   logic        CCLK = 1'b0;
   logic        rstn = 1'b0;
   logic        step = 1'b0;
   logic        run_sw = 1'b0;
   logic        clr = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [31:0] pc = 32'h0;
   logic        lcd_ack;
   logic        pipe_clk;
   logic [7:0]  tick_cnt;
   logic        lcd_req;
   logic        halted;
   logic [2:0]  state;
   logic        ack_timeout;

   logic        ack_mode = 1'b0;   // 1: ack follows lcd_req one cycle late
   logic        ack_man  = 1'b0;
   logic        ack_d    = 1'b0;

   int          n_chk = 0;
   int          n_pass = 0;
   int          rises = 0;
   int          r0, nr, c, t1, t2;
   logic        prev;
   logic [7:0]  hist;

   pipe_step_ctrl #(
      .HIGH_CYC   (HIGH_CYC),
      .RUN_DIV    (RUN_DIV),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .CCLK       (CCLK),
      .rstn       (rstn),
      .step       (step),
      .run_sw     (run_sw),
      .clr        (clr),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .lcd_ack    (lcd_ack),
      .pipe_clk   (pipe_clk),
      .tick_cnt   (tick_cnt),
      .lcd_req    (lcd_req),
      .halted     (halted),
      .state      (state),
      .ack_timeout(ack_timeout)
   );

   always #5 CCLK = ~CCLK;

   always @(posedge CCLK) ack_d <= lcd_req;
   assign lcd_ack = ack_mode ? ack_d : ack_man;

   always @(posedge pipe_clk) rises <= rises + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CCLK);
   endtask

   // Bounded wait for a given state; a timeout shows up as a failed check
   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int i;
      i = 0;
      while (state !== s && i < budget) begin
         @(negedge CCLK);
         i++;
      end
      check(tag, 32'(state), 32'(s));
   endtask

   task automatic press();
      step = 1'b1;
      cyc(1);
      step = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cyc(2);
      rstn = 1'b1;
      cyc(1);
      check("rst_pipe_clk", 32'(pipe_clk), 32'd0);
      check("rst_tick_cnt", 32'(tick_cnt), 32'd0);
      check("rst_lcd_req", 32'(lcd_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ack_timeout", 32'(ack_timeout), 32'd0);

      // Single step: 4 high, 4 low, then refresh
      step = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         hist[i] = pipe_clk;
      end
      check("step_shape", 32'(hist), 32'h0F);
      cyc(1);
      check("step_refresh_state", 32'(state), 32'd3);
      check("step_lcd_req", 32'(lcd_req), 32'd1);
      check("step_tick_cnt", 32'(tick_cnt), 32'd1);
      cyc(2);
      check("step_req_held", 32'(lcd_req), 32'd1);
      ack_man = 1'b1;
      cyc(1);
      ack_man = 1'b0;
      check("step_ack_idle", 32'(state), 32'd0);
      check("step_req_drop", 32'(lcd_req), 32'd0);
      r0 = rises;
      cyc(20);
      check("hold_no_retick_cnt", 32'(tick_cnt), 32'd1);
      check("hold_no_retick_clk", 32'(rises), 32'(r0));
      step = 1'b0;
      cyc(1);

      // Step presses during refresh are dropped
      press();
      wait_state("drop_reach_refresh", 3'd3, 20);
      step = 1'b1; cyc(1); step = 1'b0; cyc(1); step = 1'b1; cyc(1); step = 1'b0;
      ack_man = 1'b1;
      cyc(1);
      ack_man = 1'b0;
      wait_state("drop_idle", 3'd0, 5);
      cyc(15);
      check("drop_tick_cnt", 32'(tick_cnt), 32'd2);
      check("drop_rises", 32'(rises), 32'(r0 + 1));

      // clr in the TICK_HI entry cycle
      ack_mode = 1'b1;
      clr = 1'b1;
      step = 1'b1;
      cyc(1);
      clr = 1'b0;
      step = 1'b0;
      check("clr_entry_cnt", 32'(tick_cnt), 32'd0);
      check("clr_entry_state", 32'(state), 32'd1);
      wait_state("clr_idle", 3'd0, 30);

      // step_rise beats run_sw in IDLE; then drop run_sw in RUN_WAIT
      step = 1'b1;
      run_sw = 1'b1;
      cyc(1);
      step = 1'b0;
      check("rise_beats_run", 32'(state), 32'd1);
      wait_state("sim_run_wait", 3'd4, 30);
      cyc(2);
      run_sw = 1'b0;
      cyc(1);
      check("sim_run_drop", 32'(state), 32'd0);

      // Free-run: 300 ticks, period 20, count wraps to 44
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      run_sw = 1'b1;
      nr = 0; c = 0; t1 = 0; t2 = 0;
      prev = pipe_clk;
      while (nr < 300 && c < 8000) begin
         cyc(1);
         c++;
         if (pipe_clk && !prev) begin
            nr++;
            if (nr == 1) t1 = c;
            if (nr == 2) t2 = c;
         end
         prev = pipe_clk;
      end
      check("run_ticks", 32'(nr), 32'd300);
      check("run_wrap_cnt", 32'(tick_cnt), 32'd44);
      check("run_first", 32'(t1), 32'd11);
      check("run_period", 32'(t2 - t1), 32'd20);
      wait_state("run_reach_wait", 3'd4, 30);
      cyc(1);
      run_sw = 1'b0;
      cyc(1);
      check("run_stop_idle", 32'(state), 32'd0);

      // Breakpoint at PC 0x0C, PC advancing by 4 per tick from 0
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      bp_en = 1'b1;
      bp_addr = 32'h0000_000C;
      for (int k = 0; k < 4; k++) begin
         pc = 32'(4 * k);
         press();
         wait_state("bp_settle", (k == 3) ? 3'd5 : 3'd0, 40);
         check("bp_halted", 32'(halted), (k == 3) ? 32'd1 : 32'd0);
      end
      check("bp_tick_cnt", 32'(tick_cnt), 32'd4);
      pc = 32'h10;
      press();
      check("bp_step_clears", 32'(halted), 32'd0);
      check("bp_step_tick", 32'(state), 32'd1);
      wait_state("bp_pass_idle", 3'd0, 40);
      check("bp_pass_halted", 32'(halted), 32'd0);
      check("bp_pass_cnt", 32'(tick_cnt), 32'd5);
      pc = 32'h0C;
      press();
      wait_state("bp_rehalt", 3'd5, 40);
      run_sw = 1'b1;
      cyc(3);
      check("halt_run_rise_ignored", 32'(state), 32'd5);
      run_sw = 1'b0;
      cyc(1);
      check("halt_run_fall_idle", 32'(state), 32'd0);
      check("halt_run_fall_clr", 32'(halted), 32'd0);
      bp_en = 1'b0;

      // Async reset on the 2nd TICK_HI cycle
      press();
      cyc(1);
      check("rstmid_pre_clk", 32'(pipe_clk), 32'd1);
      rstn = 1'b0;
      #1;
      check("rstmid_pipe_clk", 32'(pipe_clk), 32'd0);
      check("rstmid_state", 32'(state), 32'd0);
      check("rstmid_tick_cnt", 32'(tick_cnt), 32'd0);
      check("rstmid_lcd_req", 32'(lcd_req), 32'd0);
      check("rstmid_halted", 32'(halted), 32'd0);
      check("rstmid_ack_to", 32'(ack_timeout), 32'd0);
      cyc(1);
      rstn = 1'b1;
      cyc(1);
      press();
      check("rst_first_tick", 32'(tick_cnt), 32'd1);
      wait_state("rst_idle", 3'd0, 40);

      // lcd_ack never asserted
      ack_mode = 1'b0;
      ack_man = 1'b0;
      press();
      wait_state("to_reach_refresh", 3'd3, 20);
`ifdef STEP_CTRL_ACK_TIMEOUT_EN
      cyc(7);
      check("to_req_held", 32'(lcd_req), 32'd1);
      cyc(1);
      check("to_req_drop", 32'(lcd_req), 32'd0);
      check("to_flag", 32'(ack_timeout), 32'd1);
      check("to_idle", 32'(state), 32'd0);
      ack_mode = 1'b1;
      press();
      wait_state("to_next_idle", 3'd0, 40);
      check("to_sticky", 32'(ack_timeout), 32'd1);
`else
      cyc(20);
      check("noto_state", 32'(state), 32'd3);
      check("noto_req", 32'(lcd_req), 32'd1);
      check("noto_flag", 32'(ack_timeout), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
